// File: rtl/moesi_pkg.sv
// Shared encodings for the MOESI home directory: per-cache line states,
// snoop types, the directory FSM states and helpers that convert between
// a packed 3-bit state_vec slice and the typed line state.
package moesi_pkg;

  typedef enum logic [2:0] {
    LineI = 3'b000,
    LineS = 3'b001,
    LineE = 3'b010,
    LineO = 3'b011,
    LineM = 3'b100
  } line_state_e;

  typedef enum logic [1:0] {
    SnpNone = 2'b00,
    SnpInv  = 2'b01,
    SnpFwd  = 2'b10,
    SnpRsvd = 2'b11
  } snp_type_e;

  typedef enum logic [2:0] {
    FsmIdle,
    FsmLookup,
    FsmSnoop,
    FsmWaitAck,
    FsmResp
  } dir_fsm_e;

  // Unpack one 3-bit state_vec slice into a typed line state.
  function automatic line_state_e to_line(input logic [2:0] bits);
    return line_state_e'(bits);
  endfunction

  // Pack a typed line state back into its 3-bit state_vec slice.
  function automatic logic [2:0] from_line(input line_state_e st);
    return 3'(st);
  endfunction

  // A cache holding the line in M, E or O can supply data.
  function automatic logic is_owner(input line_state_e st);
    return (st == LineM) || (st == LineE) || (st == LineO);
  endfunction

endpackage

// File: rtl/moesi_home_directory_if.sv
// Request / snoop / response bundle of the MOESI home directory.
// master: request arbiter plus cache snoop ports; slave: the directory.
interface moesi_home_directory_if #(
  parameter int unsigned NPROC = 3
);
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_proc;
  logic               req_op;
  logic               snp_valid;
  logic [NPROC-1:0]   snp_dst;
  logic [1:0]         snp_type;
  logic [NPROC-1:0]   snp_ack;
  logic               rsp_valid;
  logic [1:0]         rsp_proc;
  logic [2:0]         rsp_state;
  logic               rsp_src;
  logic [3*NPROC-1:0] state_vec;
  logic               err;

  modport master (
    output req_valid, req_proc, req_op, snp_ack,
    input  req_ready, snp_valid, snp_dst, snp_type,
    input  rsp_valid, rsp_proc, rsp_state, rsp_src, state_vec, err
  );

  modport slave (
    input  req_valid, req_proc, req_op, snp_ack,
    output req_ready, snp_valid, snp_dst, snp_type,
    output rsp_valid, rsp_proc, rsp_state, rsp_src, state_vec, err
  );
endinterface

// File: rtl/moesi_ack_collector.sv
// Sticky snoop-acknowledge mask plus WAIT_ACK timeout counter.
// clear is asserted in the SNOOP cycle; acks seen in that cycle are kept.
module moesi_ack_collector #(
  parameter int unsigned NPROC       = 3,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             active,
  input  logic [NPROC-1:0] dst,
  input  logic [NPROC-1:0] ack,
  output logic             done,
  output logic             timeout
);

  localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

  logic [NPROC-1:0] mask_q, mask_d, mask_now;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // Acks for caches outside the snoop target set never count.
  assign mask_now = mask_q | (ack & dst);
  assign done     = active && (mask_now == dst);
  // Fires during the last allowed WAIT_ACK cycle unless the acks completed.
  assign timeout  = active && !done && (cnt_q == CntW'(ACK_TIMEOUT - 1));

  // Next mask / counter: restart in SNOOP, accumulate and count in WAIT_ACK.
  always_comb begin
    mask_d = mask_q;
    cnt_d  = cnt_q;
    if (clear) begin
      mask_d = ack & dst;
      cnt_d  = '0;
    end else if (active) begin
      mask_d = mask_now;
      if (cnt_q != CntW'(ACK_TIMEOUT)) cnt_d = cnt_q + 1'b1;
    end
  end

  // Mask and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= '0;
      cnt_q  <= '0;
    end else begin
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/moesi_home_directory.sv
// Home directory for one coherent line shared by NPROC caches.
// Optional feature macro: MOESI_DIR_E_STATE_EN. Defined, a read miss with
// no peers is granted E (full MOESI); undefined, it is granted S (MOSI).
module moesi_home_directory
  import moesi_pkg::*;
#(
  parameter int unsigned NPROC       = 3,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input logic                   clk,
  input logic                   reset,
  moesi_home_directory_if.slave bus
);

  dir_fsm_e           fsm_q, fsm_d;
  logic [1:0]         proc_q;
  logic               op_q;
  logic [3*NPROC-1:0] state_vec_q, state_vec_d;
  logic               timed_out_q, timed_out_d;

  // Plan computed in LOOKUP, held until commit in the snoop path.
  logic [3*NPROC-1:0] plan_vec, plan_vec_q;
  line_state_e        plan_state, plan_state_q;
  logic               plan_src, plan_src_q;
  logic [NPROC-1:0]   plan_dst, plan_dst_q;
  snp_type_e          plan_type, plan_type_q;

  line_state_e        cur [NPROC];
  line_state_e        nxt [NPROC];
  line_state_e        req_st;
  logic [NPROC-1:0]   peer_mask, owner_mask;
  logic               owner_found;
  logic               bad_proc;
  logic               accept;
  logic               ack_done, ack_timeout;

  assign accept   = (fsm_q == FsmIdle) && bus.req_valid;
  assign bad_proc = 32'(proc_q) >= NPROC;

  // Unpack the stored state vector into per-cache line states.
  always_comb begin
    for (int i = 0; i < NPROC; i++) cur[i] = to_line(state_vec_q[3*i +: 3]);
  end

  // Classify peers and work out the snoop, grant and new state vector.
  always_comb begin
    req_st      = LineI;
    peer_mask   = '0;
    owner_mask  = '0;
    owner_found = 1'b0;
    for (int i = 0; i < NPROC; i++) begin
      nxt[i] = cur[i];
      if (2'(i) == proc_q) begin
        req_st = cur[i];
      end else if (cur[i] != LineI) begin
        peer_mask[i] = 1'b1;
        if (!owner_found && is_owner(cur[i])) begin
          owner_found   = 1'b1;
          owner_mask[i] = 1'b1;
        end
      end
    end

    plan_state = req_st;
    plan_src   = 1'b0;
    plan_dst   = '0;
    plan_type  = SnpNone;

    if (!op_q) begin
      // Reads that hit keep everything as is.
      if (req_st == LineI) begin
        plan_state = LineS;
        if (owner_found) begin
          plan_type = SnpFwd;
          plan_dst  = owner_mask;
          plan_src  = 1'b1;
          for (int i = 0; i < NPROC; i++) begin
            if (owner_mask[i]) nxt[i] = (cur[i] == LineE) ? LineS : LineO;
          end
        end else if (peer_mask == '0) begin
`ifdef MOESI_DIR_E_STATE_EN
          plan_state = LineE;
`else
          plan_state = LineS;
`endif
        end
        for (int i = 0; i < NPROC; i++) begin
          if (2'(i) == proc_q) nxt[i] = plan_state;
        end
      end
    end else if (req_st != LineM) begin
      plan_state = LineM;
      // E upgrades silently; S, O and I must invalidate every peer.
      if (req_st != LineE) begin
        plan_src = (req_st == LineI) && owner_found;
        if (peer_mask != '0) begin
          plan_type = SnpInv;
          plan_dst  = peer_mask;
        end
        for (int i = 0; i < NPROC; i++) begin
          if (peer_mask[i]) nxt[i] = LineI;
        end
      end
      for (int i = 0; i < NPROC; i++) begin
        if (2'(i) == proc_q) nxt[i] = LineM;
      end
    end

    plan_vec = '0;
    for (int i = 0; i < NPROC; i++) plan_vec[3*i +: 3] = from_line(nxt[i]);
  end

  // Directory FSM next state; state_vec commits on the edge entering RESP.
  always_comb begin
    fsm_d       = fsm_q;
    state_vec_d = state_vec_q;
    timed_out_d = timed_out_q;
    unique case (fsm_q)
      FsmIdle: begin
        if (bus.req_valid) fsm_d = FsmLookup;
      end
      FsmLookup: begin
        if (bad_proc) begin
          fsm_d = FsmIdle;
        end else if (plan_type != SnpNone) begin
          fsm_d = FsmSnoop;
        end else begin
          fsm_d       = FsmResp;
          state_vec_d = plan_vec;
        end
      end
      FsmSnoop: begin
        fsm_d = FsmWaitAck;
      end
      FsmWaitAck: begin
        if (ack_done || ack_timeout) begin
          fsm_d       = FsmResp;
          state_vec_d = plan_vec_q;
          timed_out_d = ack_timeout;
        end
      end
      FsmResp: begin
        fsm_d       = FsmIdle;
        timed_out_d = 1'b0;
      end
      default: fsm_d = FsmIdle;
    endcase
  end

  // FSM, committed state vector and timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q       <= FsmIdle;
      state_vec_q <= '0;
      timed_out_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_vec_q <= state_vec_d;
      timed_out_q <= timed_out_d;
    end
  end

  // Latch the request on acceptance and the plan at the end of LOOKUP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      proc_q       <= '0;
      op_q         <= 1'b0;
      plan_vec_q   <= '0;
      plan_state_q <= LineI;
      plan_src_q   <= 1'b0;
      plan_dst_q   <= '0;
      plan_type_q  <= SnpNone;
    end else begin
      if (accept) begin
        proc_q <= bus.req_proc;
        op_q   <= bus.req_op;
      end
      if (fsm_q == FsmLookup) begin
        plan_vec_q   <= plan_vec;
        plan_state_q <= plan_state;
        plan_src_q   <= plan_src;
        plan_dst_q   <= plan_dst;
        plan_type_q  <= plan_type;
      end
    end
  end

  moesi_ack_collector #(
    .NPROC       (NPROC),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_ack_collector (
    .clk     (clk),
    .reset   (reset),
    .clear   (fsm_q == FsmSnoop),
    .active  (fsm_q == FsmWaitAck),
    .dst     (plan_dst_q),
    .ack     (bus.snp_ack),
    .done    (ack_done),
    .timeout (ack_timeout)
  );

  // Outputs are gated to zero outside the cycle in which they are valid.
  always_comb begin
    bus.req_ready = (fsm_q == FsmIdle);
    bus.snp_valid = (fsm_q == FsmSnoop);
    bus.snp_dst   = bus.snp_valid ? plan_dst_q : '0;
    bus.snp_type  = bus.snp_valid ? plan_type_q : SnpNone;
    bus.rsp_valid = (fsm_q == FsmResp);
    bus.rsp_proc  = bus.rsp_valid ? proc_q : 2'b00;
    bus.rsp_state = bus.rsp_valid ? from_line(plan_state_q) : 3'b000;
    bus.rsp_src   = bus.rsp_valid && plan_src_q;
    bus.state_vec = state_vec_q;
    bus.err       = ((fsm_q == FsmLookup) && bad_proc) || ((fsm_q == FsmResp) && timed_out_q);
  end

endmodule

// File: tb/tb_moesi_home_directory.sv
// Directed bench for moesi_home_directory: one request per run_txn call,
// outputs sampled on the falling edge, cycle numbers relative to acceptance.
module tb_moesi_home_directory;
  import moesi_pkg::*;

  localparam int unsigned NPROC       = 3;
  localparam int unsigned ACK_TIMEOUT = 15;
  localparam int          TxnCycles   = 30;

`ifdef MOESI_DIR_E_STATE_EN
  localparam logic [2:0] ExpMiss = 3'b010;
`else
  localparam logic [2:0] ExpMiss = 3'b001;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  moesi_home_directory_if #(.NPROC(NPROC)) dif ();

  moesi_home_directory #(
    .NPROC       (NPROC),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int               snp_cyc, rsp_cyc, err_cyc, snp_cnt, rsp_cnt, err_cnt;
  logic [NPROC-1:0] snp_dst_seen;
  logic [1:0]       snp_type_seen;
  logic [1:0]       rsp_proc_seen;
  logic [2:0]       rsp_state_seen;
  logic             rsp_src_seen;
  logic [8:0]       vec_lookup;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request and watch TxnCycles cycles. ack_dly < 0 withholds acks;
  // otherwise acks for the snooped set are pulsed ack_dly cycles after SNOOP.
  // rst_at >= 1 pulses reset low for one cycle starting in that cycle.
  task automatic run_txn(input logic [1:0] proc, input logic op, input int ack_dly,
                         input int rst_at);
    snp_cyc = -1; rsp_cyc = -1; err_cyc = -1;
    snp_cnt = 0;  rsp_cnt = 0;  err_cnt = 0;
    snp_dst_seen = '0; snp_type_seen = '0;
    rsp_proc_seen = '0; rsp_state_seen = '0; rsp_src_seen = 1'b0;
    @(negedge clk);
    dif.req_valid = 1'b1;
    dif.req_proc  = proc;
    dif.req_op    = op;
    @(posedge clk);
    @(negedge clk);
    dif.req_valid = 1'b0;
    dif.req_proc  = 2'd0;
    dif.req_op    = 1'b0;
    for (int c = 1; c <= TxnCycles; c++) begin
      if (c == 1) vec_lookup = dif.state_vec;
      if (dif.snp_valid) begin
        snp_cnt++;
        if (snp_cyc < 0) snp_cyc = c;
        snp_dst_seen  = dif.snp_dst;
        snp_type_seen = dif.snp_type;
      end
      if (dif.rsp_valid) begin
        rsp_cnt++;
        if (rsp_cyc < 0) rsp_cyc = c;
        rsp_proc_seen  = dif.rsp_proc;
        rsp_state_seen = dif.rsp_state;
        rsp_src_seen   = dif.rsp_src;
      end
      if (dif.err) begin
        err_cnt++;
        if (err_cyc < 0) err_cyc = c;
      end
      dif.snp_ack = (snp_cyc >= 0 && ack_dly >= 0 && c == snp_cyc + ack_dly) ? snp_dst_seen : '0;
      if (c == rst_at) reset = 1'b0;
      else if (c == rst_at + 1) reset = 1'b1;
      @(negedge clk);
    end
    dif.snp_ack = '0;
  endtask

  initial begin
    dif.req_valid = 1'b0;
    dif.req_proc  = 2'd0;
    dif.req_op    = 1'b0;
    dif.snp_ack   = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_state_vec", 32'(dif.state_vec), 32'h0);
    check_eq("reset_req_ready", 32'(dif.req_ready), 32'h1);
    check_eq("reset_outputs", 32'({dif.snp_valid, dif.snp_dst, dif.snp_type, dif.rsp_valid,
                                   dif.rsp_proc, dif.rsp_state, dif.rsp_src, dif.err}), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // P0 read miss, no peers: E (MOESI) or S (MOSI) from memory.
    run_txn(2'd0, 1'b0, 0, -1);
    check_eq("rd_miss_rsp_cyc", 32'(rsp_cyc), 32'd2);
    check_eq("rd_miss_rsp_state", 32'(rsp_state_seen), 32'(ExpMiss));
    check_eq("rd_miss_rsp_src", 32'(rsp_src_seen), 32'd0);
    check_eq("rd_miss_rsp_proc", 32'(rsp_proc_seen), 32'd0);
    check_eq("rd_miss_no_snp", 32'(snp_cnt), 32'd0);
    check_eq("rd_miss_vec_in_lookup", 32'(vec_lookup), 32'h0);
    check_eq("rd_miss_vec", 32'(dif.state_vec), 32'({6'b0, ExpMiss}));

    // P0 write: upgrade to M without snoop, then write again unchanged.
    run_txn(2'd0, 1'b1, 0, -1);
    check_eq("wr1_rsp_cyc", 32'(rsp_cyc), 32'd2);
    check_eq("wr1_rsp_state", 32'(rsp_state_seen), 32'd4);
    check_eq("wr1_no_snp", 32'(snp_cnt), 32'd0);
    check_eq("wr1_vec", 32'(dif.state_vec), 32'h004);
    run_txn(2'd0, 1'b1, 0, -1);
    check_eq("wr2_rsp_cyc", 32'(rsp_cyc), 32'd2);
    check_eq("wr2_rsp_state", 32'(rsp_state_seen), 32'd4);
    check_eq("wr2_vec", 32'(dif.state_vec), 32'h004);

    // P1 read with P0=M: FWD to P0, ack in the SNOOP cycle, 4-cycle latency.
    run_txn(2'd1, 1'b0, 0, -1);
    check_eq("fwd_snp_cyc", 32'(snp_cyc), 32'd2);
    check_eq("fwd_snp_cnt", 32'(snp_cnt), 32'd1);
    check_eq("fwd_snp_dst", 32'(snp_dst_seen), 32'b001);
    check_eq("fwd_snp_type", 32'(snp_type_seen), 32'b10);
    check_eq("fwd_rsp_cyc", 32'(rsp_cyc), 32'd4);
    check_eq("fwd_rsp_proc", 32'(rsp_proc_seen), 32'd1);
    check_eq("fwd_rsp_state", 32'(rsp_state_seen), 32'd1);
    check_eq("fwd_rsp_src", 32'(rsp_src_seen), 32'd1);
    check_eq("fwd_vec", 32'(dif.state_vec), 32'h00B);
    check_eq("fwd_no_err", 32'(err_cnt), 32'd0);

    // P1 write from S with P0=O: INV to P0, ack two cycles after SNOOP.
    run_txn(2'd1, 1'b1, 2, -1);
    check_eq("inv_snp_dst", 32'(snp_dst_seen), 32'b001);
    check_eq("inv_snp_type", 32'(snp_type_seen), 32'b01);
    check_eq("inv_rsp_cyc", 32'(rsp_cyc), 32'd5);
    check_eq("inv_rsp_state", 32'(rsp_state_seen), 32'd4);
    check_eq("inv_rsp_src", 32'(rsp_src_seen), 32'd0);
    check_eq("inv_vec", 32'(dif.state_vec), 32'h020);

    // P2 read with P1=M: FWD to P1, P1 becomes O and P2 S.
    run_txn(2'd2, 1'b0, 1, -1);
    check_eq("fwd2_snp_dst", 32'(snp_dst_seen), 32'b010);
    check_eq("fwd2_rsp_cyc", 32'(rsp_cyc), 32'd4);
    check_eq("fwd2_rsp_src", 32'(rsp_src_seen), 32'd1);
    check_eq("fwd2_vec", 32'(dif.state_vec), 32'h058);

    // P0 write from I with acks withheld: timeout after ACK_TIMEOUT cycles.
    run_txn(2'd0, 1'b1, -1, -1);
    check_eq("to_snp_dst", 32'(snp_dst_seen), 32'b110);
    check_eq("to_snp_type", 32'(snp_type_seen), 32'b01);
    check_eq("to_rsp_cyc", 32'(rsp_cyc), 32'(3 + ACK_TIMEOUT));
    check_eq("to_err_cyc", 32'(err_cyc), 32'(3 + ACK_TIMEOUT));
    check_eq("to_err_cnt", 32'(err_cnt), 32'd1);
    check_eq("to_rsp_state", 32'(rsp_state_seen), 32'd4);
    check_eq("to_rsp_src", 32'(rsp_src_seen), 32'd1);
    check_eq("to_vec", 32'(dif.state_vec), 32'h004);

    // Out-of-range requester: error in LOOKUP, nothing else happens.
    run_txn(2'd3, 1'b0, 0, -1);
    check_eq("bad_err_cyc", 32'(err_cyc), 32'd1);
    check_eq("bad_err_cnt", 32'(err_cnt), 32'd1);
    check_eq("bad_no_rsp", 32'(rsp_cnt), 32'd0);
    check_eq("bad_no_snp", 32'(snp_cnt), 32'd0);
    check_eq("bad_vec", 32'(dif.state_vec), 32'h004);
    check_eq("bad_ready", 32'(dif.req_ready), 32'd1);

    // Reset during WAIT_ACK: transaction dropped, late ack ignored.
    run_txn(2'd1, 1'b0, 5, 4);
    check_eq("rst_snp_cnt", 32'(snp_cnt), 32'd1);
    check_eq("rst_no_rsp", 32'(rsp_cnt), 32'd0);
    check_eq("rst_no_err", 32'(err_cnt), 32'd0);
    check_eq("rst_vec", 32'(dif.state_vec), 32'h0);
    check_eq("rst_ready", 32'(dif.req_ready), 32'd1);

    // Fresh read after the reset works normally.
    run_txn(2'd2, 1'b0, 0, -1);
    check_eq("post_rst_rsp_cyc", 32'(rsp_cyc), 32'd2);
    check_eq("post_rst_rsp_proc", 32'(rsp_proc_seen), 32'd2);
    check_eq("post_rst_vec", 32'(dif.state_vec), 32'({ExpMiss, 6'b0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/moesi_home_directory.md
# moesi_home_directory

Home-node responder for one coherent line shared by NPROC caches. It accepts read/write requests from the processor-side request path, looks up the per-cache MOESI state it holds, and issues invalidate/forward snoops to peer caches. It collects their acknowledgements, commits the new state vector and returns a grant response. It sits between the request arbiter and the cache snoop ports and is the authoritative copy of every cache's line state.

## Interface
- NPROC, 3: number of caches tracked; req_proc width is 2, so NPROC ≤ 4.
- ACK_TIMEOUT, 15: maximum cycles spent in WAIT_ACK before a forced completion.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  directory can accept a request; high only in IDLE.
- req_proc  in  2  requesting cache index.
- req_op  in  1  0 = read, 1 = write.
- snp_valid  out  1  single-cycle snoop issue strobe.
- snp_dst  out  NPROC  one-hot or multi-hot snoop target mask.
- snp_type  out  2  00 none, 01 INV, 10 FWD (supply data and downgrade), 11 reserved.
- snp_ack  in  NPROC  per-cache acknowledge pulses.
- rsp_valid  out  1  single-cycle grant strobe.
- rsp_proc  out  2  grant target.
- rsp_state  out  3  state granted to the requester.
- rsp_src  out  1  data source: 0 = memory or no data needed, 1 = owning cache.
- state_vec  out  3*NPROC  current state per cache; cache i occupies bits [3i+2:3i].
- err  out  1  single-cycle error strobe.

## Operation
- State encoding: I=000, S=001, E=010, O=011, M=100.
- FSM: IDLE → LOOKUP → (RESP | SNOOP → WAIT_ACK → RESP) → IDLE.
- A request is accepted on a clock edge where req_valid and req_ready are both high. req_proc and req_op are latched at that edge.
- The peer set is every cache other than the requester whose state is not I. The owner is the single peer in M, E or O, if any.
- Read, requester not in I: hit. No snoop. rsp_state = current state, rsp_src = 0.
- Read, requester in I, owner present: FWD sent to the owner. Owner goes M→O, E→S, O→O. Requester goes to S, rsp_src = 1.
- Read, requester in I, peers are S only: requester goes to S, rsp_src = 0, no snoop.
- Read, requester in I, no peers: requester goes to E, rsp_src = 0.
- Write, requester in M: no change, no snoop.
- Write, requester in E: silent upgrade to M, no snoop.
- Write, requester in S, O or I: INV sent to every peer. All peers go to I. Requester goes to M.
  - rsp_src = 1 if the requester was I and an owner existed; otherwise rsp_src = 0.
- A write from S or O with an empty peer set skips SNOOP.
- WAIT_ACK keeps a sticky mask of received acks. snp_ack bits for non-targeted caches are ignored. An ack arriving in the SNOOP cycle counts.
- When the ack mask equals snp_dst, the FSM moves to RESP.
- Timeout: after ACK_TIMEOUT cycles in WAIT_ACK, err pulses, the planned state update is still committed, and the FSM goes to RESP.
- req_proc ≥ NPROC: the request is accepted, err pulses in the LOOKUP cycle, the FSM returns to IDLE, and no response is sent.

## Timing
- Reset: FSM in IDLE; state_vec all I; req_ready = 1; all other outputs 0.
  - Reset asserted mid-transaction aborts it. No response is sent, and acks arriving after reset release are ignored.
- Acceptance is edge T. LOOKUP occupies cycle T+1.
- No-snoop path: rsp_valid is high in cycle T+2.
- Snoop path: snp_valid is high in cycle T+2. If the last ack is collected at edge A, rsp_valid is high in the cycle after A.
  - Minimum latency is 4 cycles when acks arrive in the SNOOP cycle.
- state_vec changes on the same edge that raises rsp_valid.
- req_ready returns high in the cycle after RESP, so back-to-back requests sustain one per 3 cycles without snoops.
- snp_dst and snp_type are valid only while snp_valid is high. They are 0 otherwise.

## Configuration
- MOESI_DIR_E_STATE_EN defined: full MOESI behaviour as described above.
- Undefined: MOSI behaviour. A read miss with no peers grants S instead of E, and E never appears in state_vec. The E-related rules become unreachable.

## Structure
- moesi_pkg: state encodings, snp_type encodings, FSM state enum, and a function that packs/unpacks state_vec slices.
- Sub-module moesi_ack_collector: holds the sticky ack mask and the timeout counter. It exposes done and timeout signals and is cleared in SNOOP.

## Test plan
- Reset, then P0 read → rsp_state 010 (E), rsp_src 0, state_vec {I,I,E}, no snp_valid.
- P0 write, then P0 write again → first write: M with no snoop; second write: unchanged M, rsp at T+2 both times.
- From P0=M, P1 read → FWD with snp_dst 001; ack → P0=O, P1=S, rsp_src 1.
- From P0=O and P1=S, P1 write → INV with snp_dst 001; ack → P0=I, P1=M. Then P2 read → P1=O, P2=S.
- INV issued with ack withheld → err pulse and rsp exactly ACK_TIMEOUT cycles into WAIT_ACK; state committed.
- req_proc = 3 → err pulse, no rsp_valid, state_vec unchanged. Also: reset asserted during WAIT_ACK → all I, no response.
